// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the fetch front end.
package rv32i_pkg;

  // Default datapath width.
  localparam int unsigned DefaultXlen = 32;

  // addi x0, x0, 0 -- presented on the decode bus whenever no instruction is valid.
  localparam logic [31:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Synchronous FIFO with head-of-queue output, flush and occupancy count.
module rv32i_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Overflow/underflow are blocked here so a misbehaving caller cannot corrupt pointers.
  assign do_push = push_i && (count_q != CntW'(Depth));
  assign do_pop  = pop_i && (count_q != '0);

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // Pointer, count and storage update; flush empties the queue but leaves storage as is.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/rv32i_fetch_buffer.sv
// Instruction fetch buffer: issues credit-limited memory requests, tracks their PCs,
// buffers returned words for decode and discards responses orphaned by a redirect.
module rv32i_fetch_buffer #(
  parameter int unsigned XLEN  = rv32i_pkg::DefaultXlen,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            fetch_valid_i,
  input  logic [XLEN-1:0] fetch_address_i,
  output logic            fetch_ready_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_instr_o,
  output logic            dec_misalign_o
);

  import rv32i_pkg::*;

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PcqW  = XLEN + 1;
  localparam int unsigned IbufW = 2 * XLEN + 1;

  logic [CntW-1:0]  out_cnt, occ, drop_q, drop_d;
  logic [CntW+1:0]  used;
  logic             pop, credit, grant, misalign, rsp_take, rsp_drop, flush_sub;
  logic [PcqW-1:0]  pcq_head;
  logic [IbufW-1:0] ibuf_head;

  assign pop      = dec_valid_o && dec_ready_i;
  // Entries already committed (in flight, to be dropped, buffered) minus the one leaving now.
  assign used     = {2'b00, out_cnt} + {2'b00, drop_q} + {2'b00, occ}
                  - {{(CntW + 1){1'b0}}, pop};
  assign credit   = used < (CntW + 2)'(DEPTH);

  assign imem_req_o    = fetch_valid_i && credit && !flush_i && !reset;
  assign imem_addr_o   = {fetch_address_i[XLEN-1:2], 2'b00};
  assign grant         = imem_req_o && imem_gnt_i;
  assign fetch_ready_o = grant;
  assign misalign      = fetch_address_i[1:0] != 2'b00;

  assign rsp_drop  = imem_rvalid_i && (drop_q != '0);
  assign rsp_take  = imem_rvalid_i && (drop_q == '0) && (out_cnt != '0) && !flush_i;
  assign flush_sub = imem_rvalid_i && ((drop_q != '0) || (out_cnt != '0));

  // On redirect every live request becomes a pending drop, less one answered this cycle.
  always_comb begin
    drop_d = drop_q;
    if (flush_i) begin
      drop_d = drop_q + out_cnt - CntW'(flush_sub);
    end else if (rsp_drop) begin
      drop_d = drop_q - CntW'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  // PCs of granted requests awaiting their response; its count is out_cnt.
  rv32i_sync_fifo #(
    .Width (PcqW),
    .Depth (DEPTH)
  ) u_pc_queue (
    .clk_i   (clk_in),
    .rst_i   (reset),
    .flush_i (flush_i),
    .push_i  (grant),
    .data_i  ({fetch_address_i, misalign}),
    .pop_i   (rsp_take),
    .data_o  (pcq_head),
    .count_o (out_cnt)
  );

  // Returned instructions waiting for decode: {pc, instr, misalign}.
  rv32i_sync_fifo #(
    .Width (IbufW),
    .Depth (DEPTH)
  ) u_instr_buf (
    .clk_i   (clk_in),
    .rst_i   (reset),
    .flush_i (flush_i),
    .push_i  (rsp_take),
    .data_i  ({pcq_head[PcqW-1:1], imem_rdata_i, pcq_head[0]}),
    .pop_i   (pop),
    .data_o  (ibuf_head),
    .count_o (occ)
  );

  assign dec_valid_o    = (occ != '0) && !reset;
  assign dec_pc_o       = dec_valid_o ? ibuf_head[IbufW-1:XLEN+1] : '0;
  assign dec_misalign_o = dec_valid_o && ibuf_head[0];
  // Zero while in reset, NOP whenever the buffer is otherwise empty.
  assign dec_instr_o    = dec_valid_o ? ibuf_head[XLEN:1] :
                          (reset ? '0 : XLEN'(NopInstr));

endmodule

// File: doc/rv32i_fetch_buffer.md
RV32I_FETCH_BUFFER -- requirements
Module: rv32i_fetch_buffer

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; DEPTH, default 2, instruction buffer entries and maximum in-flight memory requests.
REQ-002 The block SHALL use one clock, clk_in; reset is synchronous and active-high, port reset.
REQ-003 clk_in  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_valid_i  input  1  fetch stage presents an address.
REQ-006 fetch_address_i  input  XLEN  PC to fetch.
REQ-007 fetch_ready_o  output  1  address accepted this cycle.
REQ-008 flush_i  input  1  redirect; discard all buffered and in-flight instructions.
REQ-009 imem_req_o  output  1  memory request valid.
REQ-010 imem_addr_o  output  XLEN  word-aligned request address.
REQ-011 imem_gnt_i  input  1  memory accepts request this cycle.
REQ-012 imem_rvalid_i  input  1  read data valid; responses return in request order, latency >= 1 cycle.
REQ-013 imem_rdata_i  input  XLEN  instruction word.
REQ-014 dec_valid_o  output  1  buffer head valid toward decode.
REQ-015 dec_ready_i  input  1  decode accepts head.
REQ-016 dec_pc_o  output  XLEN  PC of head instruction.
REQ-017 dec_instr_o  output  XLEN  head instruction word.
REQ-018 dec_misalign_o  output  1  head PC had address[1:0] != 0.

Function
REQ-019 Counters SHALL be: out_cnt (live requests granted, no response yet), drop_cnt (requests to discard), occ (buffer entries); all range 0..DEPTH.
REQ-020 pop = dec_valid_o && dec_ready_i; credit = (out_cnt + drop_cnt + occ - pop) < DEPTH.
REQ-021 imem_req_o SHALL equal fetch_valid_i && credit && !flush_i && !reset.
REQ-022 imem_addr_o SHALL equal {fetch_address_i[XLEN-1:2], 2'b00}.
REQ-023 fetch_ready_o SHALL equal imem_req_o && imem_gnt_i; on that cycle the PC and misalign bit are pushed into a PC queue and out_cnt increments.
REQ-024 imem_rvalid_i with drop_cnt > 0 SHALL decrement drop_cnt and discard the data.
REQ-025 imem_rvalid_i with drop_cnt == 0 and out_cnt > 0 SHALL pop the PC queue, push {pc, rdata, misalign} into the instruction buffer, and decrement out_cnt.
REQ-026 imem_rvalid_i with drop_cnt == 0 and out_cnt == 0 is a protocol violation; it SHALL be ignored with no state change.
REQ-027 Best-case latency SHALL be: grant at cycle N, rvalid at N+1, dec_valid_o high at N+2 (registered buffer, no bypass).
REQ-028 Buffer SHALL be FIFO order; dec_* outputs come from the head entry and hold stable while dec_valid_o && !dec_ready_i.
REQ-029 Simultaneous push and pop SHALL leave occ unchanged; at occ == DEPTH, credit prevents further requests, so the buffer never overflows.
REQ-030 flush_i SHALL, in the same edge: set occ = 0, clear the PC queue, set out_cnt = 0, and set drop_cnt = drop_cnt + out_cnt - (imem_rvalid_i ? 1 : 0).
REQ-031 A response arriving in the flush cycle SHALL be discarded; no request is issued in the flush cycle.
REQ-032 dec_valid_o SHALL be 0 in the cycle after flush_i.
REQ-033 Steady state, with 1-cycle memory, DEPTH = 2, and decode always ready, SHALL sustain one instruction per cycle.

Reset
REQ-034 While reset is high, imem_req_o = 0, fetch_ready_o = 0, and dec_valid_o = 0.
REQ-035 On the first edge with reset high: out_cnt = drop_cnt = occ = 0; dec_pc_o, dec_instr_o, and dec_misalign_o = 0.
REQ-036 Reset mid-operation SHALL abandon in-flight responses without a drop count; the environment guarantees memory is also reset.

Structure
REQ-037 XLEN default and the NOP constant 32'h0000_0013 (used for dec_instr_o when invalid) SHALL live in shared package rv32i_pkg.
REQ-038 The PC queue and the instruction buffer SHALL each be an instance of sub-module rv32i_sync_fifo (parameterised width/depth, push/pop/flush, count output).

Verification
REQ-039 Back-to-back: addresses 0x0, 0x4, 0x8, gnt always 1, rvalid 1 cycle later with 0x11,0x22,0x33, dec_ready=1 -> dec outputs (0x0,0x11),(0x4,0x22),(0x8,0x33) on consecutive cycles starting cycle 2.
REQ-040 Backpressure: dec_ready=0 for 6 cycles -> exactly 2 grants, then imem_req_o=0; head (0x0,0x11) held stable; release -> ordered drain.
REQ-041 Flush in flight: 2 requests granted, flush_i asserted before responses -> both responses discarded, drop_cnt returns to 0; next fetch 0x100 delivers its own data only.
REQ-042 Flush coincident with rvalid -> that response discarded and no request that cycle; dec_valid_o=0 the next cycle.
REQ-043 Misaligned: fetch_address_i=0x102 -> imem_addr_o=0x100, dec_pc_o=0x102, dec_misalign_o=1.
REQ-044 Reset asserted with an entry buffered and 1 request outstanding -> all counters 0 and dec_valid_o=0 next cycle; a stray rvalid afterwards is ignored.
